ahb_master_arbiter: RTL and testbench
=====================================

// Module: ahb_master_arbiter
// PURPOSE
//  Round-robin arbiter that shares one AHB slave port (ahb_slave_if) among NUM_MASTERS masters.
//  Issues one-hot grants and sequences address/data-phase owner indices for the external
//  address, control and write-data muxes. Fixed-length bursts are never broken.
//  INCR bursts may be pre-empted after INCR_MAX_BEATS beats.
// PARAMETERS
//  NUM_MASTERS     4   requesting masters, legal 2..8
//  DEFAULT_MASTER  0   parked owner when nothing is requested, must be < NUM_MASTERS
//  INCR_MAX_BEATS  16  max beats of an INCR burst before forced re-arbitration, legal 2..256
// PORTS
//  ahb_clk_in      in   1        bus clock, all flops on posedge
//  ahb_rstn_in     in   1        async active-low reset
//  mst_req_in      in   N        per-master bus request
//  ahb_trans_in    in   2        HTRANS of current address-phase owner (post-mux)
//  ahb_burst_in    in   3        HBURST of current address-phase owner (post-mux)
//  ahb_ready_in    in   1        HREADY from slave
//  ahb_resp_in     in   1        HRESP from slave (1 = ERROR)
//  mst_grant_out   out  N        one-hot grant, registered
//  addr_mst_out    out  clog2N   address-phase owner index (addr/ctrl mux select)
//  data_mst_out    out  clog2N   data-phase owner index (wdata mux / rdata route)
//  arb_busy_out    out  1        1 when state != S_PARK
// BEHAVIOUR
//  Reset (async, any time, aborts any burst):
//   - mst_grant_out = 1<<DEFAULT_MASTER; addr_mst_out = data_mst_out = DEFAULT_MASTER.
//   - arb_busy_out = 0; rr_ptr = DEFAULT_MASTER; beat_cnt = 0; state = S_PARK.
//  Beat = posedge with ahb_ready_in=1. Nothing updates on a posedge with ahb_ready_in=0.
//  ARB (round-robin pick), performed at a beat:
//   - Search mst_req_in from (rr_ptr+1) mod N upward; the first set bit wins.
//   - Winner: grant <= winner, rr_ptr <= winner.
//   - No request set: grant <= DEFAULT_MASTER, next state S_PARK, rr_ptr unchanged.
//   - Grant may re-select the same master.
//  Owner pipeline, at every beat:
//   - data_mst_out <= addr_mst_out.
//   - addr_mst_out <= index(mst_grant_out), sampled before the grant update.
//   - Result: a grant change reaches the address mux one beat later, the data mux two beats later.
//  States (ahb_trans_in/ahb_burst_in evaluated at the beat):
//   S_PARK: any request -> ARB, go to S_OWN.
//   S_OWN:
//    - IDLE, or NONSEQ+SINGLE -> ARB, stay in S_OWN (S_PARK if no request).
//    - NONSEQ + WRAP4/INCR4 / WRAP8/INCR8 / WRAP16/INCR16 -> beat_cnt <= 3/7/15, go to S_FIX, grant held.
//    - NONSEQ+INCR -> beat_cnt <= INCR_MAX_BEATS-1, go to S_INCR, grant held.
//    - BUSY/SEQ in S_OWN (protocol error) -> treated as IDLE.
//   S_FIX:
//    - SEQ -> beat_cnt-1. SEQ with beat_cnt==1 -> ARB, go to S_OWN (new grant covers next address).
//    - BUSY -> hold beat_cnt.
//    - IDLE (master cancels after ERROR) -> beat_cnt <= 0, ARB, go to S_OWN.
//    - NONSEQ: treated as a new S_OWN NONSEQ decode (reload).
//    - mst_req_in drop by the owner is ignored until the burst ends.
//   S_INCR:
//    - SEQ -> beat_cnt-1; BUSY -> hold.
//    - IDLE or NONSEQ -> ARB, go to S_OWN.
//    - SEQ with beat_cnt==1: another master requesting -> ARB, go to S_OWN; none -> reload INCR_MAX_BEATS-1.
//  ERROR (ahb_resp_in=1, ahb_ready_in=0): no action; the following beat is decoded normally.
//  beat_cnt is 8 bits, never wraps below 0. Grant always one-hot, never all-zero.
// TESTING
//  1. Reset, no req -> grant=0001, addr=data=0, busy=0.
//     Assert rstn mid-S_FIX (cnt=5) -> same values immediately.
//  2. req=1010, owner 0, rr_ptr=0, IDLE beat -> grant=0010; next beat addr=1; next beat data=1.
//  3. M1 NONSEQ INCR4, M2 requesting -> grant held for 3 SEQ beats (BUSY + ready=0 inserted).
//     Grant=0100 after 3rd SEQ beat.
//  4. M3 INCR, INCR_MAX_BEATS=4, M0 requesting -> after 3 SEQ beats grant=0001.
//     Repeat with no other request -> grant stays 1000.
//  5. M2 WRAP8, ERROR after 2nd SEQ, master drives IDLE -> re-arbitration on that IDLE beat, cnt=0.
//  6. All req=1111 with SINGLE transfers -> grants 0,1,2,3,0,... with no master granted twice in a row.

Source files
------------

// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB master arbiter: one-hot registered grant plus address/data-phase owner indices.
// Grant changes at a beat and reach the addr mux 1 beat and the data mux 2 beats later; HREADY low freezes everything.
module ahb_master_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int INCR_MAX_BEATS = 16
) (
    input  logic                           ahb_clk_in,
    input  logic                           ahb_rstn_in,
    input  logic [NUM_MASTERS-1:0]         mst_req_in,
    input  logic [1:0]                     ahb_trans_in,
    input  logic [2:0]                     ahb_burst_in,
    input  logic                           ahb_ready_in,
    input  logic                           ahb_resp_in,
    output logic [NUM_MASTERS-1:0]         mst_grant_out,
    output logic [$clog2(NUM_MASTERS)-1:0] addr_mst_out,
    output logic [$clog2(NUM_MASTERS)-1:0] data_mst_out,
    output logic                           arb_busy_out
);

    localparam int IW = $clog2(NUM_MASTERS);

    localparam logic [NUM_MASTERS-1:0] GNT_ONE     = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] DEF_GNT     = GNT_ONE << DEFAULT_MASTER;
    localparam logic [IW-1:0]          DEF_IDX     = IW'(DEFAULT_MASTER);
    localparam logic [7:0]             INCR_RELOAD = 8'(INCR_MAX_BEATS - 1);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam logic [2:0] HB_WRAP4  = 3'd2;
    localparam logic [2:0] HB_INCR4  = 3'd3;
    localparam logic [2:0] HB_WRAP8  = 3'd4;
    localparam logic [2:0] HB_INCR8  = 3'd5;
    localparam logic [2:0] HB_WRAP16 = 3'd6;
    localparam logic [2:0] HB_INCR16 = 3'd7;

    typedef enum logic [1:0] {S_PARK, S_OWN, S_FIX, S_INCR} state_t;

    state_t                  state_q, state_d;
    logic [NUM_MASTERS-1:0]  grant_q, grant_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]           addr_mst_q, addr_mst_d;
    logic [IW-1:0]           data_mst_q, data_mst_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;

    logic                    do_arb;
    logic                    do_decode;
    logic [IW:0]             pick;
    logic                    pick_vld;
    logic [IW-1:0]           pick_idx;
    logic                    other_req;
    logic                    resp_unused;

    // HRESP needs no action: the first error cycle has HREADY low, the second is an ordinary beat.
    assign resp_unused = ahb_resp_in;

    function automatic logic [IW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IW-1:0]          ptr);
        logic        found;
        logic [IW:0] res;
        int          cand;
        found = 1'b0;
        res   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = (int'(ptr) + i) % NUM_MASTERS;
            if (!found && req[IW'(cand)]) begin
                found = 1'b1;
                res   = {1'b1, IW'(cand)};
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] gnt_idx(input logic [NUM_MASTERS-1:0] g);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (g[IW'(i)]) r = IW'(i);
        end
        return r;
    endfunction

    assign pick      = rr_pick(mst_req_in, rr_ptr_q);
    assign pick_vld  = pick[IW];
    assign pick_idx  = pick[IW-1:0];
    assign other_req = |(mst_req_in & ~grant_q);

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state_q    <= S_PARK;
            grant_q    <= DEF_GNT;
            rr_ptr_q   <= DEF_IDX;
            addr_mst_q <= DEF_IDX;
            data_mst_q <= DEF_IDX;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            addr_mst_q <= addr_mst_d;
            data_mst_q <= data_mst_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        addr_mst_d = addr_mst_q;
        data_mst_d = data_mst_q;
        beat_cnt_d = beat_cnt_q;
        do_arb     = 1'b0;
        do_decode  = 1'b0;

        if (ahb_ready_in) begin
            data_mst_d = addr_mst_q;
            addr_mst_d = gnt_idx(grant_q);

            case (state_q)
                S_PARK: begin
                    if (|mst_req_in) do_arb = 1'b1;
                end
                S_OWN: begin
                    do_decode = 1'b1;
                end
                S_FIX: begin
                    case (ahb_trans_in)
                        HT_SEQ: begin
                            if (beat_cnt_q <= 8'd1) begin
                                beat_cnt_d = 8'd0;
                                do_arb     = 1'b1;
                            end else begin
                                beat_cnt_d = beat_cnt_q - 8'd1;
                            end
                        end
                        HT_BUSY: ;
                        HT_NONSEQ: do_decode = 1'b1;
                        default: begin
                            beat_cnt_d = 8'd0;
                            do_arb     = 1'b1;
                        end
                    endcase
                end
                S_INCR: begin
                    case (ahb_trans_in)
                        HT_SEQ: begin
                            if (beat_cnt_q > 8'd1) begin
                                beat_cnt_d = beat_cnt_q - 8'd1;
                            end else if (other_req) begin
                                beat_cnt_d = 8'd0;
                                do_arb     = 1'b1;
                            end else begin
                                beat_cnt_d = INCR_RELOAD;
                            end
                        end
                        HT_BUSY: ;
                        default: begin
                            beat_cnt_d = 8'd0;
                            do_arb     = 1'b1;
                        end
                    endcase
                end
                default: do_arb = 1'b1;
            endcase

            // Only a NONSEQ burst start locks the grant; anything else is a re-arbitration point.
            if (do_decode) begin
                if (ahb_trans_in == HT_NONSEQ && ahb_burst_in != HB_SINGLE) begin
                    case (ahb_burst_in)
                        HB_INCR: begin
                            beat_cnt_d = INCR_RELOAD;
                            state_d    = S_INCR;
                        end
                        HB_WRAP4, HB_INCR4: begin
                            beat_cnt_d = 8'd3;
                            state_d    = S_FIX;
                        end
                        HB_WRAP8, HB_INCR8: begin
                            beat_cnt_d = 8'd7;
                            state_d    = S_FIX;
                        end
                        HB_WRAP16, HB_INCR16: begin
                            beat_cnt_d = 8'd15;
                            state_d    = S_FIX;
                        end
                        default: begin
                            beat_cnt_d = 8'd0;
                            do_arb     = 1'b1;
                        end
                    endcase
                end else begin
                    beat_cnt_d = 8'd0;
                    do_arb     = 1'b1;
                end
            end

            if (do_arb) begin
                if (pick_vld) begin
                    grant_d  = GNT_ONE << pick_idx;
                    rr_ptr_d = pick_idx;
                    state_d  = S_OWN;
                end else begin
                    grant_d  = DEF_GNT;
                    state_d  = S_PARK;
                end
            end
        end
    end

    always_comb begin
        mst_grant_out = grant_q;
        addr_mst_out  = addr_mst_q;
        data_mst_out  = data_mst_q;
        arb_busy_out  = (state_q != S_PARK);
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter with INCR_MAX_BEATS=4; outputs sampled 1ns after posedge.
module tb_ahb_master_arbiter;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, WRAP8 = 3'd4, INCR8 = 3'd5;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic       resp;
    logic [3:0] gnt;
    logic [1:0] addr;
    logic [1:0] data;
    logic       busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    ahb_master_arbiter #(
        .NUM_MASTERS    (4),
        .DEFAULT_MASTER (0),
        .INCR_MAX_BEATS (4)
    ) dut (
        .ahb_clk_in    (clk),
        .ahb_rstn_in   (rstn),
        .mst_req_in    (req),
        .ahb_trans_in  (trans),
        .ahb_burst_in  (burst),
        .ahb_ready_in  (ready),
        .ahb_resp_in   (resp),
        .mst_grant_out (gnt),
        .addr_mst_out  (addr),
        .data_mst_out  (data),
        .arb_busy_out  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input logic [3:0] r, input logic [1:0] t, input logic [2:0] b,
                        input logic rdy, input logic rsp);
        req = r; trans = t; burst = b; ready = rdy; resp = rsp;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = 4'b0000; trans = IDLE; burst = SINGLE; ready = 1'b1; resp = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        chk_cnt++; if (gnt !== 4'b0001) $display("FAIL rst_grant: got %b want 0001", gnt); else pass_cnt++;
        chk_cnt++; if (addr !== 2'd0) $display("FAIL rst_addr: got %0d want 0", addr); else pass_cnt++;
        chk_cnt++; if (data !== 2'd0) $display("FAIL rst_data: got %0d want 0", data); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        step(4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0001 || busy !== 1'b0)
            $display("FAIL park_idle: got grant %b busy %b want 0001 0", gnt, busy); else pass_cnt++;
        // Drive M1 into an INCR8 burst and reset it with beat_cnt at 5.
        step(4'b0010, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0010, NONSEQ, INCR8, 1'b1, 1'b0);
        step(4'b0010, SEQ, INCR8, 1'b1, 1'b0);
        step(4'b0010, SEQ, INCR8, 1'b1, 1'b0);
        chk_cnt++; if (dut.beat_cnt_q !== 8'd5 || gnt !== 4'b0010)
            $display("FAIL fix_pre_rst: got cnt %0d grant %b want 5 0010", dut.beat_cnt_q, gnt); else pass_cnt++;
        #3 rstn = 1'b0;
        #1;
        chk_cnt++; if (gnt !== 4'b0001 || addr !== 2'd0 || data !== 2'd0)
            $display("FAIL midburst_rst: got grant %b addr %0d data %0d want 0001 0 0", gnt, addr, data); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0 || dut.beat_cnt_q !== 8'd0)
            $display("FAIL midburst_rst_state: got busy %b cnt %0d want 0 0", busy, dut.beat_cnt_q); else pass_cnt++;
        #2 rstn = 1'b1;
    endtask

    task automatic test_owner_pipeline();
        apply_reset();
        step(4'b1010, IDLE, SINGLE, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0010 || addr !== 2'd0 || data !== 2'd0)
            $display("FAIL pipe_b1: got grant %b addr %0d data %0d want 0010 0 0", gnt, addr, data); else pass_cnt++;
        step(4'b1010, IDLE, SINGLE, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b1000 || addr !== 2'd1 || data !== 2'd0)
            $display("FAIL pipe_b2: got grant %b addr %0d data %0d want 1000 1 0", gnt, addr, data); else pass_cnt++;
        step(4'b1010, IDLE, SINGLE, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0010 || addr !== 2'd3 || data !== 2'd1)
            $display("FAIL pipe_b3: got grant %b addr %0d data %0d want 0010 3 1", gnt, addr, data); else pass_cnt++;
        step(4'b1010, IDLE, SINGLE, 1'b0, 1'b0);
        chk_cnt++; if (gnt !== 4'b0010 || addr !== 2'd3 || data !== 2'd1)
            $display("FAIL pipe_stall: got grant %b addr %0d data %0d want 0010 3 1", gnt, addr, data); else pass_cnt++;
        step(4'b0000, IDLE, SINGLE, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0001 || busy !== 1'b0 || addr !== 2'd1)
            $display("FAIL pipe_park: got grant %b busy %b addr %0d want 0001 0 1", gnt, busy, addr); else pass_cnt++;
    endtask

    task automatic test_fixed_burst();
        apply_reset();
        step(4'b0010, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0110, NONSEQ, INCR4, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0010 || dut.beat_cnt_q !== 8'd3)
            $display("FAIL fix_start: got grant %b cnt %0d want 0010 3", gnt, dut.beat_cnt_q); else pass_cnt++;
        // Owner drops its request mid-burst; the grant must stay put.
        step(4'b0100, SEQ, INCR4, 1'b1, 1'b0);
        step(4'b0100, BUSY, INCR4, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0010 || dut.beat_cnt_q !== 8'd2)
            $display("FAIL fix_busy: got grant %b cnt %0d want 0010 2", gnt, dut.beat_cnt_q); else pass_cnt++;
        step(4'b0100, SEQ, INCR4, 1'b0, 1'b0);
        chk_cnt++; if (dut.beat_cnt_q !== 8'd2)
            $display("FAIL fix_stall: got cnt %0d want 2", dut.beat_cnt_q); else pass_cnt++;
        step(4'b0100, SEQ, INCR4, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0010 || busy !== 1'b1)
            $display("FAIL fix_seq2: got grant %b busy %b want 0010 1", gnt, busy); else pass_cnt++;
        step(4'b0100, SEQ, INCR4, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0100)
            $display("FAIL fix_end: got grant %b want 0100", gnt); else pass_cnt++;
    endtask

    task automatic test_incr_preempt();
        apply_reset();
        step(4'b1000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b1001, NONSEQ, INCR, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b1000 || dut.beat_cnt_q !== 8'd3)
            $display("FAIL incr_start: got grant %b cnt %0d want 1000 3", gnt, dut.beat_cnt_q); else pass_cnt++;
        step(4'b1001, SEQ, INCR, 1'b1, 1'b0);
        step(4'b1001, SEQ, INCR, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b1000)
            $display("FAIL incr_hold: got grant %b want 1000", gnt); else pass_cnt++;
        step(4'b1001, SEQ, INCR, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b0001)
            $display("FAIL incr_preempt: got grant %b want 0001", gnt); else pass_cnt++;

        apply_reset();
        step(4'b1000, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b1000, NONSEQ, INCR, 1'b1, 1'b0);
        step(4'b1000, SEQ, INCR, 1'b1, 1'b0);
        step(4'b1000, SEQ, INCR, 1'b1, 1'b0);
        step(4'b1000, SEQ, INCR, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b1000 || dut.beat_cnt_q !== 8'd3)
            $display("FAIL incr_reload: got grant %b cnt %0d want 1000 3", gnt, dut.beat_cnt_q); else pass_cnt++;
        step(4'b1000, SEQ, INCR, 1'b1, 1'b0);
        chk_cnt++; if (gnt !== 4'b1000 || dut.beat_cnt_q !== 8'd2)
            $display("FAIL incr_after_reload: got grant %b cnt %0d want 1000 2", gnt, dut.beat_cnt_q); else pass_cnt++;
    endtask

    task automatic test_error_cancel();
        apply_reset();
        step(4'b0100, IDLE, SINGLE, 1'b1, 1'b0);
        step(4'b0101, NONSEQ, WRAP8, 1'b1, 1'b0);
        step(4'b0101, SEQ, WRAP8, 1'b1, 1'b0);
        step(4'b0101, SEQ, WRAP8, 1'b1, 1'b0);
        step(4'b0101, SEQ, WRAP8, 1'b0, 1'b1);
        chk_cnt++; if (gnt !== 4'b0100 || dut.beat_cnt_q !== 8'd5)
            $display("FAIL err_first: got grant %b cnt %0d want 0100 5", gnt, dut.beat_cnt_q); else pass_cnt++;
        step(4'b0101, IDLE, WRAP8, 1'b1, 1'b1);
        chk_cnt++; if (gnt !== 4'b0001 || dut.beat_cnt_q !== 8'd0 || busy !== 1'b1)
            $display("FAIL err_cancel: got grant %b cnt %0d busy %b want 0001 0 1", gnt, dut.beat_cnt_q, busy); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] prev_g;
        apply_reset();
        exp_g = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            prev_g = gnt;
            step(4'b1111, NONSEQ, SINGLE, 1'b1, 1'b0);
            chk_cnt++; if (gnt !== exp_g || gnt === prev_g)
                $display("FAIL rr_beat%0d: got %b prev %b want %b", i, gnt, prev_g, exp_g); else pass_cnt++;
            exp_g = {exp_g[2:0], exp_g[3]};
        end
    endtask

    initial begin
        rstn  = 1'b0;
        req   = 4'b0000;
        trans = IDLE;
        burst = SINGLE;
        ready = 1'b1;
        resp  = 1'b0;
        test_reset();
        test_owner_pipeline();
        test_fixed_burst();
        test_incr_preempt();
        test_error_cancel();
        test_round_robin();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
